// File: rtl/bin_onehot_pkg.sv
// Shared command encodings and FSM state type for the registered one-hot sequencer.
package bin_onehot_pkg;

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_ROTL  = 2'b01;
  localparam logic [1:0] MODE_ROTR  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  typedef enum logic [0:0] {
    ST_EMPTY,
    ST_ACTIVE
  } state_e;

endpackage

// File: rtl/onehot_rotate.sv
// Combinational circular barrel rotator over W bits (W need not be a power of 2).
// The caller guarantees amt_i < W.
module onehot_rotate #(
  parameter int unsigned W     = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic [W-1:0]     vec_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             dir_i,  // 0: rotate left, 1: rotate right
  output logic [W-1:0]     vec_o
);

  // One extra bit so that W itself is representable; W - 0 = W shifts everything out.
  localparam logic [AMT_W:0] WLim = (AMT_W + 1)'(W);

  logic [AMT_W:0] inv_amt;
  logic [W-1:0]   rot_l;
  logic [W-1:0]   rot_r;

  // Rotate as the OR of a forward shift and the complementary backward shift.
  always_comb begin
    inv_amt = WLim - {1'b0, amt_i};
    rot_l   = (vec_i << amt_i) | (vec_i >> inv_amt);
    rot_r   = (vec_i >> amt_i) | (vec_i << inv_amt);
    vec_o   = dir_i ? rot_r : rot_l;
  end

endmodule

// File: rtl/bin_onehot_seq.sv
// Registered one-hot state vector driven by LOAD / ROTL / ROTR / CLEAR commands,
// with a single-entry valid/ready output stage reporting the vector and its index.
module bin_onehot_seq
  import bin_onehot_pkg::*;
#(
  parameter int unsigned BIN_W     = 4,
  parameter int unsigned ONE_HOT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           mode_i,
  input  logic [BIN_W-1:0]     bin_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ONE_HOT_W-1:0] one_hot_o,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_o
);

  localparam logic [BIN_W:0] WLim = (BIN_W + 1)'(ONE_HOT_W);

  state_e                 state_q, nxt_state;
  logic [ONE_HOT_W-1:0]   cur_q, nxt_vec, rot_vec;
  logic [BIN_W-1:0]       bin_q, nxt_bin;
  logic                   err_q, nxt_err;
  logic                   out_valid_q;
  logic                   in_range;
  logic                   accept;

  assign in_ready_o  = !out_valid_q || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;
  assign in_range    = ({1'b0, bin_i} < WLim);

  // The state register doubles as the output vector: both only change on accept.
  assign out_valid_o = out_valid_q;
  assign one_hot_o   = cur_q;
  assign bin_o       = bin_q;
  assign err_o       = err_q;

  onehot_rotate #(
    .W     (ONE_HOT_W),
    .AMT_W (BIN_W)
  ) u_rotate (
    .vec_i (cur_q),
    .amt_i (bin_i),
    .dir_i (mode_i == MODE_ROTR),
    .vec_o (rot_vec)
  );

  // Next vector, state and error flag for the presented command.
  always_comb begin
    nxt_vec   = cur_q;
    nxt_state = state_q;
    nxt_err   = 1'b0;
    unique case (mode_i)
      MODE_LOAD: begin
        if (in_range) begin
          nxt_vec   = ONE_HOT_W'(1) << bin_i;
          nxt_state = ST_ACTIVE;
        end else begin
          nxt_err = 1'b1;
        end
      end
      MODE_ROTL, MODE_ROTR: begin
        if (in_range && (state_q == ST_ACTIVE)) begin
          nxt_vec = rot_vec;
        end else begin
          nxt_err = 1'b1;
        end
      end
      MODE_CLEAR: begin
        nxt_vec   = '0;
        nxt_state = ST_EMPTY;
      end
      default: ;
    endcase
  end

  // One-hot to binary encode; the vector holds at most one set bit so OR-ing indices is exact.
  always_comb begin
    nxt_bin = '0;
    for (int i = 0; i < int'(ONE_HOT_W); i++) begin
      if (nxt_vec[i]) nxt_bin = nxt_bin | BIN_W'(i);
    end
  end

  // FSM, state vector and output register; reset drops any in-flight result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      cur_q       <= '0;
      bin_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      state_q     <= nxt_state;
      cur_q       <= nxt_vec;
      bin_q       <= nxt_bin;
      err_q       <= nxt_err;
      out_valid_q <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bin_onehot_seq.sv
// Directed self-checking bench: a 16-bit instance and a 10-bit (non power of 2) instance.
module tb_bin_onehot_seq;

  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] ROTL  = 2'b01;
  localparam logic [1:0] ROTR  = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 16-bit instance
  logic        rst16 = 1'b1, iv16 = 1'b0, or16 = 1'b1;
  logic [1:0]  mode16 = 2'b00;
  logic [3:0]  bi16 = 4'd0;
  logic        ir16, ov16, er16;
  logic [15:0] oh16;
  logic [3:0]  bo16;

  // 10-bit instance
  logic        rst10 = 1'b1, iv10 = 1'b0, or10 = 1'b1;
  logic [1:0]  mode10 = 2'b00;
  logic [3:0]  bi10 = 4'd0;
  logic        ir10, ov10, er10;
  logic [9:0]  oh10;
  logic [3:0]  bo10;

  bin_onehot_seq #(.BIN_W(4), .ONE_HOT_W(16)) dut16 (
    .clk_i(clk), .rst_i(rst16), .in_valid_i(iv16), .in_ready_o(ir16), .mode_i(mode16),
    .bin_i(bi16), .out_valid_o(ov16), .out_ready_i(or16), .one_hot_o(oh16), .bin_o(bo16),
    .err_o(er16)
  );

  bin_onehot_seq #(.BIN_W(4), .ONE_HOT_W(10)) dut10 (
    .clk_i(clk), .rst_i(rst10), .in_valid_i(iv10), .in_ready_o(ir10), .mode_i(mode10),
    .bin_i(bi10), .out_valid_o(ov10), .out_ready_i(or10), .one_hot_o(oh10), .bin_o(bo10),
    .err_o(er10)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd16(input logic [1:0] m, input logic [3:0] b);
    iv16 = 1'b1; mode16 = m; bi16 = b;
    @(posedge clk); #1;
    iv16 = 1'b0;
  endtask

  task automatic cmd10(input logic [1:0] m, input logic [3:0] b);
    iv10 = 1'b1; mode10 = m; bi10 = b;
    @(posedge clk); #1;
    iv10 = 1'b0;
  endtask

  task automatic res16(input string tag, input logic [15:0] oh, input logic [3:0] b,
                       input logic e);
    chk({tag, ".valid"}, 32'(ov16), 32'd1);
    chk({tag, ".one_hot"}, 32'(oh16), 32'(oh));
    chk({tag, ".bin"}, 32'(bo16), 32'(b));
    chk({tag, ".err"}, 32'(er16), 32'(e));
  endtask

  task automatic res10(input string tag, input logic [9:0] oh, input logic [3:0] b,
                       input logic e);
    chk({tag, ".valid"}, 32'(ov10), 32'd1);
    chk({tag, ".one_hot"}, 32'(oh10), 32'(oh));
    chk({tag, ".bin"}, 32'(bo10), 32'(b));
    chk({tag, ".err"}, 32'(er10), 32'(e));
  endtask

  initial begin
    // Reset both instances
    repeat (2) @(posedge clk);
    #1;
    rst16 = 1'b0; rst10 = 1'b0;
    chk("rst.valid", 32'(ov16), 32'd0);
    chk("rst.one_hot", 32'(oh16), 32'd0);
    chk("rst.bin", 32'(bo16), 32'd0);
    chk("rst.err", 32'(er16), 32'd0);
    chk("rst.in_ready", 32'(ir16), 32'd1);

    // Basic load and rotations on the 16-bit instance
    cmd16(LOAD, 4'd5);   res16("load5", 16'h0020, 4'd5, 1'b0);
    cmd16(LOAD, 4'd15);  res16("load15", 16'h8000, 4'd15, 1'b0);
    cmd16(ROTL, 4'd1);   res16("rotl1_wrap", 16'h0001, 4'd0, 1'b0);
    cmd16(ROTR, 4'd3);   res16("rotr3", 16'h2000, 4'd13, 1'b0);
    cmd16(ROTL, 4'd0);   res16("rotl0", 16'h2000, 4'd13, 1'b0);
    cmd16(ROTL, 4'd15);  res16("rotl15", 16'h1000, 4'd12, 1'b0);
    cmd16(CLEAR, 4'd7);  res16("clear", 16'h0000, 4'd0, 1'b0);
    cmd16(ROTR, 4'd1);   res16("empty_rotr", 16'h0000, 4'd0, 1'b1);
    cmd16(CLEAR, 4'd0);  res16("clear_empty", 16'h0000, 4'd0, 1'b0);

    // Result consumed with no new command: valid drops
    @(posedge clk); #1;
    chk("idle.valid", 32'(ov16), 32'd0);

    // Back-pressure: A=LOAD 3 accepted, B=LOAD 7 stalled for 3 cycles
    or16 = 1'b0;
    cmd16(LOAD, 4'd3);
    res16("bp.A", 16'h0008, 4'd3, 1'b0);
    chk("bp.A.in_ready", 32'(ir16), 32'd0);
    iv16 = 1'b1; mode16 = LOAD; bi16 = 4'd7;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp.stall.in_ready", 32'(ir16), 32'd0);
      res16("bp.stall", 16'h0008, 4'd3, 1'b0);
    end
    or16 = 1'b1; #1;
    chk("bp.release.in_ready", 32'(ir16), 32'd1);
    @(posedge clk); #1;
    iv16 = 1'b0;
    res16("bp.B", 16'h0080, 4'd7, 1'b0);
    @(posedge clk); #1;
    chk("bp.drain.valid", 32'(ov16), 32'd0);

    // Reset while a result is pending and a command is presented
    or16 = 1'b0;
    cmd16(LOAD, 4'd2);
    res16("rstmid.pending", 16'h0004, 4'd2, 1'b0);
    iv16 = 1'b1; mode16 = LOAD; bi16 = 4'd4; rst16 = 1'b1;
    @(posedge clk); #1;
    rst16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;
    chk("rstmid.valid", 32'(ov16), 32'd0);
    chk("rstmid.one_hot", 32'(oh16), 32'd0);
    chk("rstmid.bin", 32'(bo16), 32'd0);
    cmd16(ROTL, 4'd1);   res16("rstmid.rotl_empty", 16'h0000, 4'd0, 1'b1);

    // 10-bit instance: range checks and wrap within 10 bits
    cmd10(LOAD, 4'd9);   res10("w10.load9", 10'h200, 4'd9, 1'b0);
    cmd10(LOAD, 4'd12);  res10("w10.load12_err", 10'h200, 4'd9, 1'b1);
    cmd10(LOAD, 4'd10);  res10("w10.load10_err", 10'h200, 4'd9, 1'b1);
    cmd10(ROTL, 4'd2);   res10("w10.rotl2", 10'h002, 4'd1, 1'b0);
    cmd10(ROTR, 4'd12);  res10("w10.rotr12_err", 10'h002, 4'd1, 1'b1);
    cmd10(ROTR, 4'd3);   res10("w10.rotr3", 10'h100, 4'd8, 1'b0);
    cmd10(ROTL, 4'd9);   res10("w10.rotl9", 10'h080, 4'd7, 1'b0);
    cmd10(CLEAR, 4'd0);  res10("w10.clear", 10'h000, 4'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
